rename_regfile: RTL and testbench
=================================

Name: rename_regfile

Overview:
- Architectural register file with per-register rename tags. It sits between the decoder and the reorder buffer.
- It is the receiving end of the ROB commit interface (write enable, register id, ROB id, value) and of the ROB flush signal.
- For each of two source operands it tells the decoder either the committed value or the ROB entry that will produce it.

Parameters:
REG_ID_BIT, 5, width of an architectural register index (2^REG_ID_BIT registers)
ROB_WIDTH_BIT, 3, width of a ROB entry id (tag)

Ports:
clk_in  input  1  clock; all state updates on rising edge
rst_in  input  1  synchronous, active-high reset
rdy_in  input  1  low = pause; all state held
issue_en  input  1  decoder issues an instruction that writes issue_rd
issue_rd  input  REG_ID_BIT  destination register of issued instruction
issue_rob_id  input  ROB_WIDTH_BIT  ROB entry allocated to the issued instruction
rs1_id  input  REG_ID_BIT  source register 1 index
rs2_id  input  REG_ID_BIT  source register 2 index
rs1_busy  output  1  rs1 awaits an in-flight producer
rs1_tag  output  ROB_WIDTH_BIT  producer ROB id for rs1 (valid when rs1_busy)
rs1_value  output  32  committed value of rs1 (valid when !rs1_busy)
rs2_busy, rs2_tag, rs2_value  output  1/ROB_WIDTH_BIT/32  same semantics for rs2
commit_en  input  1  ROB commit write
commit_reg  input  REG_ID_BIT  committed destination register
commit_rob_id  input  ROB_WIDTH_BIT  ROB entry being committed
commit_value  input  32  committed result
clear_all  input  1  misprediction flush from ROB

Behaviour:
- State per register: value[31:0], busy, tag[ROB_WIDTH_BIT-1:0].
- Reset (rst_in=1 at edge): every value=0, busy=0, tag=0. The read outputs are combinational from this state, so after reset they show busy=0, tag=0, value=0.
- Pause: if rdy_in=0 and rst_in=0, no state changes. Read outputs still track state.
- Register 0: never busy, reads value 0 and tag 0. Commits and issues to register 0 are ignored.
- Commit (commit_en=1, commit_reg!=0):
  - value[commit_reg] <= commit_value.
  - busy is cleared only if busy=1 and tag==commit_rob_id.
  - Otherwise busy and tag are unchanged, because a newer producer owns the register.
- Issue (issue_en=1, issue_rd!=0, clear_all=0): busy[issue_rd] <= 1, tag[issue_rd] <= issue_rob_id.
- Issue and commit to the same register in the same cycle: the value takes commit_value, and busy/tag take the issue (issue wins).
- clear_all=1:
  - Every busy is set to 0; tags are left unchanged (don't-care).
  - An issue in the same cycle is dropped.
  - A commit in the same cycle still writes its value; the ROB never drives both, but the regfile must tolerate it.
- Reads are combinational, zero latency, from current state.
- Issue does not forward into reads. The decoder reads sources before its own destination is renamed, so an instruction with rd==rs1 sees the old mapping.
- No stall outputs; the block always accepts.

Optional Feature:
- Macro: REGFILE_COMMIT_BYPASS_EN.
- Defined: a read port forwards the same-cycle commit when commit_en=1, commit_reg==rsN_id!=0, busy=1 and tag==commit_rob_id. In that case rsN_busy=0 and rsN_value=commit_value.
- Undefined: reads reflect registered state only, so the result becomes visible one cycle after the commit edge.

Decomposition:
- Shared constants package/header holds REG_ID_BIT, ROB_WIDTH_BIT and the register count.
- One sub-module, regfile_read_port, instantiated twice: index mux plus the optional bypass compare.
- Write/rename logic stays in the top module.

Test Plan:
- Reset, then read rs1_id=5 and rs2_id=0 -> busy=0, value=0, tag=0 on both.
- Issue rd=5 tag=3; next cycle read rs1_id=5 -> busy=1, tag=3. Then commit reg=5 rob=3 value=0xDEADBEEF -> next cycle busy=0, value=0xDEADBEEF.
- Issue rd=7 tag=1, then issue rd=7 tag=4, then commit reg=7 rob=1 value=0x11 -> value=0x11, busy=1, tag=4. Commit rob=4 value=0x22 -> busy=0, value=0x22.
- Same cycle: commit reg=9 rob=2 value=0x55 and issue rd=9 tag=6 -> value=0x55, busy=1, tag=6.
- Issue rd=3, 4 and 10 with tags 0, 1, 2, then pulse clear_all with issue_en=1 rd=12 -> all busy=0, including 12. Commit to reg 0 with value 0x99 -> reads 0.
- With REGFILE_COMMIT_BYPASS_EN: busy reg 8 with tag 5, commit reg=8 rob=5 value=0x77 while rs2_id=8 -> same cycle rs2_busy=0, rs2_value=0x77. Without the macro: rs2_busy=1 that cycle, 0/0x77 next cycle. rdy_in=0 during a commit -> no state change.

Source files
------------

// File: rtl/rename_regfile_pkg.sv
// rtl/rename_regfile_pkg.sv - shared sizing constants for the rename register file
// Purpose: architectural register index width, ROB tag width, register count,
//          and the data word width shared by the top and its read ports.
// Ports:   none (package).
package rename_regfile_pkg;

  localparam int RF_REG_ID_BIT    = 5;
  localparam int RF_ROB_WIDTH_BIT = 3;
  localparam int RF_NUM_REGS      = 1 << RF_REG_ID_BIT;
  localparam int RF_DATA_W        = 32;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one source-operand read port of the rename register file
// Purpose: selects value/busy/tag for one source register; register 0 always
//          reads as not busy, value 0, tag 0. With REGFILE_COMMIT_BYPASS_EN
//          defined, a same-cycle commit that retires the register's current
//          producer is forwarded straight to the outputs.
// Ports:   rs_id                            source register index
//          value_arr/busy_arr/tag_arr       registered per-register state
//          commit_en/reg/rob_id/value       same-cycle commit (bypass only)
//          rs_busy/rs_tag/rs_value          combinational read result
module regfile_read_port #(
  parameter int REG_ID_BIT    = 5,
  parameter int ROB_WIDTH_BIT = 3,
  parameter int NUM_REGS      = 1 << REG_ID_BIT
) (
  input  logic [REG_ID_BIT-1:0]    rs_id,
  input  logic [31:0]              value_arr [NUM_REGS],
  input  logic                     busy_arr  [NUM_REGS],
  input  logic [ROB_WIDTH_BIT-1:0] tag_arr   [NUM_REGS],
  input  logic                     commit_en,
  input  logic [REG_ID_BIT-1:0]    commit_reg,
  input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
  input  logic [31:0]              commit_value,
  output logic                     rs_busy,
  output logic [ROB_WIDTH_BIT-1:0] rs_tag,
  output logic [31:0]              rs_value
);

  logic is_zero;
  assign is_zero = (rs_id == '0);

`ifdef REGFILE_COMMIT_BYPASS_EN
  // Forward only when the commit retires the producer the register is waiting
  // on; a stale commit must not hide a newer in-flight producer.
  logic bypass_hit;
  assign bypass_hit = commit_en && !is_zero && (commit_reg == rs_id) &&
                      busy_arr[rs_id] && (tag_arr[rs_id] == commit_rob_id);

  always_comb begin
    rs_busy  = 1'b0;
    rs_tag   = '0;
    rs_value = '0;
    if (!is_zero) begin
      rs_tag = tag_arr[rs_id];
      if (bypass_hit) begin
        rs_busy  = 1'b0;
        rs_value = commit_value;
      end else begin
        rs_busy  = busy_arr[rs_id];
        rs_value = value_arr[rs_id];
      end
    end
  end
`else
  logic unused_commit;
  assign unused_commit = ^{commit_en, commit_reg, commit_rob_id, commit_value};

  always_comb begin
    rs_busy  = 1'b0;
    rs_tag   = '0;
    rs_value = '0;
    if (!is_zero) begin
      rs_busy  = busy_arr[rs_id];
      rs_tag   = tag_arr[rs_id];
      rs_value = value_arr[rs_id];
    end
  end
`endif

endmodule

// File: rtl/rename_regfile.sv
// rtl/rename_regfile.sv - architectural register file with per-register rename tags
// Purpose: holds committed values and, per register, whether an in-flight ROB
//          entry will produce it (busy + tag). Sits between decoder and ROB.
//          Optional macro: REGFILE_COMMIT_BYPASS_EN (same-cycle commit forwarding
//          into the read ports).
// Ports:   clk_in, rst_in (sync, active high), rdy_in (low = hold all state)
//          issue_en/issue_rd/issue_rob_id        rename of a destination
//          rs1_id/rs2_id -> rsN_busy/rsN_tag/rsN_value   combinational reads
//          commit_en/commit_reg/commit_rob_id/commit_value  ROB commit write
//          clear_all                              misprediction flush
module rename_regfile
  import rename_regfile_pkg::*;
#(
  parameter int REG_ID_BIT    = RF_REG_ID_BIT,
  parameter int ROB_WIDTH_BIT = RF_ROB_WIDTH_BIT
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     issue_en,
  input  logic [REG_ID_BIT-1:0]    issue_rd,
  input  logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
  input  logic [REG_ID_BIT-1:0]    rs1_id,
  input  logic [REG_ID_BIT-1:0]    rs2_id,
  output logic                     rs1_busy,
  output logic [ROB_WIDTH_BIT-1:0] rs1_tag,
  output logic [31:0]              rs1_value,
  output logic                     rs2_busy,
  output logic [ROB_WIDTH_BIT-1:0] rs2_tag,
  output logic [31:0]              rs2_value,
  input  logic                     commit_en,
  input  logic [REG_ID_BIT-1:0]    commit_reg,
  input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
  input  logic [31:0]              commit_value,
  input  logic                     clear_all
);

  localparam int NUM_REGS = 1 << REG_ID_BIT;

  logic [31:0]              value_q [NUM_REGS];
  logic [31:0]              value_d [NUM_REGS];
  logic                     busy_q  [NUM_REGS];
  logic                     busy_d  [NUM_REGS];
  logic [ROB_WIDTH_BIT-1:0] tag_q   [NUM_REGS];
  logic [ROB_WIDTH_BIT-1:0] tag_d   [NUM_REGS];

  // Order matters: commit first, then flush, then issue, so a same-cycle issue
  // overrides the commit's busy clear, and a flush drops the issue.
  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;

    if (commit_en && (commit_reg != '0)) begin
      value_d[commit_reg] = commit_value;
      // Only the producer the register is still waiting on may clear busy.
      if (busy_q[commit_reg] && (tag_q[commit_reg] == commit_rob_id)) begin
        busy_d[commit_reg] = 1'b0;
      end
    end

    if (clear_all) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        busy_d[i] = 1'b0;
      end
    end else if (issue_en && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
      tag_d[issue_rd]  = issue_rob_id;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        value_q[i] <= '0;
        busy_q[i]  <= 1'b0;
        tag_q[i]   <= '0;
      end
    end else if (rdy_in) begin
      value_q <= value_d;
      busy_q  <= busy_d;
      tag_q   <= tag_d;
    end
  end

  regfile_read_port #(
    .REG_ID_BIT    (REG_ID_BIT),
    .ROB_WIDTH_BIT (ROB_WIDTH_BIT),
    .NUM_REGS      (NUM_REGS)
  ) u_rd_port1 (
    .rs_id         (rs1_id),
    .value_arr     (value_q),
    .busy_arr      (busy_q),
    .tag_arr       (tag_q),
    .commit_en     (commit_en),
    .commit_reg    (commit_reg),
    .commit_rob_id (commit_rob_id),
    .commit_value  (commit_value),
    .rs_busy       (rs1_busy),
    .rs_tag        (rs1_tag),
    .rs_value      (rs1_value)
  );

  regfile_read_port #(
    .REG_ID_BIT    (REG_ID_BIT),
    .ROB_WIDTH_BIT (ROB_WIDTH_BIT),
    .NUM_REGS      (NUM_REGS)
  ) u_rd_port2 (
    .rs_id         (rs2_id),
    .value_arr     (value_q),
    .busy_arr      (busy_q),
    .tag_arr       (tag_q),
    .commit_en     (commit_en),
    .commit_reg    (commit_reg),
    .commit_rob_id (commit_rob_id),
    .commit_value  (commit_value),
    .rs_busy       (rs2_busy),
    .rs_tag        (rs2_tag),
    .rs_value      (rs2_value)
  );

endmodule

// File: tb/tb_rename_regfile.sv
// tb/tb_rename_regfile.sv - self-checking bench for rename_regfile
module tb_rename_regfile;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic [2:0]  issue_rob_id;
  logic [4:0]  rs1_id, rs2_id;
  logic        rs1_busy, rs2_busy;
  logic [2:0]  rs1_tag, rs2_tag;
  logic [31:0] rs1_value, rs2_value;
  logic        commit_en;
  logic [4:0]  commit_reg;
  logic [2:0]  commit_rob_id;
  logic [31:0] commit_value;
  logic        clear_all;

  int total = 0;
  int bad   = 0;

  // Reference model: what each register holds and which ROB entry owns it.
  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [2:0]  m_tag  [32];

  always #5 clk_in = ~clk_in;

  rename_regfile dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_value(rs1_value),
    .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_value(rs2_value),
    .commit_en(commit_en), .commit_reg(commit_reg),
    .commit_rob_id(commit_rob_id), .commit_value(commit_value),
    .clear_all(clear_all)
  );

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  // Expected read of one register given the model and the inputs now applied.
  task automatic model_read(input logic [4:0] id, output logic b, output logic [2:0] t,
                            output logic [31:0] v);
    b = 1'b0; t = 3'd0; v = 32'd0;
    if (id != 5'd0) begin
      b = m_busy[id]; t = m_tag[id]; v = m_val[id];
`ifdef REGFILE_COMMIT_BYPASS_EN
      if (commit_en && commit_reg == id && m_busy[id] && m_tag[id] == commit_rob_id) begin
        b = 1'b0; v = commit_value;
      end
`endif
    end
  endtask

  task automatic check_reads();
    logic b; logic [2:0] t; logic [31:0] v;
    model_read(rs1_id, b, t, v);
    chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, b});
    if (!b) chk("rs1_value", rs1_value, v);
    else    chk("rs1_tag", {29'd0, rs1_tag}, {29'd0, t});
    model_read(rs2_id, b, t, v);
    chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, b});
    if (!b) chk("rs2_value", rs2_value, v);
    else    chk("rs2_tag", {29'd0, rs2_tag}, {29'd0, t});
  endtask

  task automatic model_clock();
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 32'd0; m_busy[i] = 1'b0; m_tag[i] = 3'd0;
      end
    end else if (rdy_in) begin
      if (commit_en && commit_reg != 5'd0) begin
        m_val[commit_reg] = commit_value;
        if (m_busy[commit_reg] && m_tag[commit_reg] == commit_rob_id)
          m_busy[commit_reg] = 1'b0;
      end
      if (clear_all) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (issue_en && issue_rd != 5'd0) begin
        m_busy[issue_rd] = 1'b1;
        m_tag[issue_rd]  = issue_rob_id;
      end
    end
  endtask

  // Drive one cycle's inputs, check reads against the model before the edge,
  // then clock and advance the model.
  task automatic step(input logic rst, input logic rdy,
                      input logic ien, input logic [4:0] ird, input logic [2:0] irob,
                      input logic cen, input logic [4:0] creg, input logic [2:0] crob,
                      input logic [31:0] cval, input logic clr,
                      input logic [4:0] r1, input logic [4:0] r2);
    rst_in = rst; rdy_in = rdy;
    issue_en = ien; issue_rd = ird; issue_rob_id = irob;
    commit_en = cen; commit_reg = creg; commit_rob_id = crob; commit_value = cval;
    clear_all = clr; rs1_id = r1; rs2_id = r2;
    #2;
    if (!rst) check_reads();
    @(posedge clk_in);
    model_clock();
    #1;
  endtask

  task automatic peek(input logic [4:0] r1, input logic [4:0] r2);
    rst_in = 1'b0; rdy_in = 1'b1; issue_en = 1'b0; commit_en = 1'b0; clear_all = 1'b0;
    rs1_id = r1; rs2_id = r2;
    #2;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 32'd0; m_busy[i] = 1'b0; m_tag[i] = 3'd0;
    end

    // Reset
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    peek(5, 0);
    chk("rst_rs1_busy", {31'd0, rs1_busy}, 32'd0);
    chk("rst_rs1_value", rs1_value, 32'd0);
    chk("rst_rs1_tag", {29'd0, rs1_tag}, 32'd0);
    chk("rst_rs2_busy", {31'd0, rs2_busy}, 32'd0);
    chk("rst_rs2_value", rs2_value, 32'd0);
    chk("rst_rs2_tag", {29'd0, rs2_tag}, 32'd0);

    // Issue then commit
    step(0, 1, 1, 5, 3, 0, 0, 0, 0, 0, 5, 0);
    peek(5, 0);
    chk("iss5_busy", {31'd0, rs1_busy}, 32'd1);
    chk("iss5_tag", {29'd0, rs1_tag}, 32'd3);
    step(0, 1, 0, 0, 0, 1, 5, 3, 32'hDEADBEEF, 0, 5, 0);
    peek(5, 0);
    chk("cmt5_busy", {31'd0, rs1_busy}, 32'd0);
    chk("cmt5_value", rs1_value, 32'hDEADBEEF);

    // Stale commit keeps the newer producer
    step(0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 7, 0);
    step(0, 1, 1, 7, 4, 0, 0, 0, 0, 0, 7, 0);
    step(0, 1, 0, 0, 0, 1, 7, 1, 32'h11, 0, 7, 0);
    peek(7, 0);
    chk("stale_busy", {31'd0, rs1_busy}, 32'd1);
    chk("stale_tag", {29'd0, rs1_tag}, 32'd4);
    chk("stale_value", dut.value_q[7], 32'h11);
    step(0, 1, 0, 0, 0, 1, 7, 4, 32'h22, 0, 7, 0);
    peek(7, 0);
    chk("own_busy", {31'd0, rs1_busy}, 32'd0);
    chk("own_value", rs1_value, 32'h22);

    // Same-cycle issue and commit: issue wins busy/tag, commit wins value
    step(0, 1, 1, 9, 6, 1, 9, 2, 32'h55, 0, 9, 0);
    peek(0, 9);
    chk("same_busy", {31'd0, rs2_busy}, 32'd1);
    chk("same_tag", {29'd0, rs2_tag}, 32'd6);
    chk("same_value", dut.value_q[9], 32'h55);

    // Flush drops busy everywhere and the concurrent issue
    step(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 3, 4);
    step(0, 1, 1, 4, 1, 0, 0, 0, 0, 0, 3, 4);
    step(0, 1, 1, 10, 2, 0, 0, 0, 0, 0, 3, 10);
    step(0, 1, 1, 12, 5, 0, 0, 0, 0, 1, 3, 10);
    peek(3, 4);
    chk("clr_b3", {31'd0, rs1_busy}, 32'd0);
    chk("clr_b4", {31'd0, rs2_busy}, 32'd0);
    peek(10, 12);
    chk("clr_b10", {31'd0, rs1_busy}, 32'd0);
    chk("clr_b12", {31'd0, rs2_busy}, 32'd0);

    // Register 0 ignores commits and issues
    step(0, 1, 1, 0, 3, 1, 0, 0, 32'h99, 0, 0, 0);
    peek(0, 0);
    chk("r0_value", rs1_value, 32'd0);
    chk("r0_busy", {31'd0, rs1_busy}, 32'd0);

    // Same-cycle commit visibility on rs2
    step(0, 1, 1, 8, 5, 0, 0, 0, 0, 0, 0, 8);
    rst_in = 0; rdy_in = 1; issue_en = 0; clear_all = 0;
    commit_en = 1; commit_reg = 8; commit_rob_id = 5; commit_value = 32'h77;
    rs1_id = 0; rs2_id = 8;
    #2;
`ifdef REGFILE_COMMIT_BYPASS_EN
    chk("byp_busy", {31'd0, rs2_busy}, 32'd0);
    chk("byp_value", rs2_value, 32'h77);
`else
    chk("nobyp_busy", {31'd0, rs2_busy}, 32'd1);
`endif
    @(posedge clk_in);
    model_clock();
    #1;
    peek(0, 8);
    chk("post_busy", {31'd0, rs2_busy}, 32'd0);
    chk("post_value", rs2_value, 32'h77);

    // Pause holds everything
    step(0, 0, 1, 13, 2, 1, 11, 0, 32'h1234, 0, 11, 13);
    peek(11, 13);
    chk("pause_value", rs1_value, 32'd0);
    chk("pause_busy", {31'd0, rs2_busy}, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [4:0] cr;
      logic [2:0] cb;
      cr = 5'($urandom_range(0, 9));
      cb = ($urandom_range(0, 1) == 1) ? m_tag[cr] : 3'($urandom);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
           1'($urandom), 5'($urandom_range(0, 9)), 3'($urandom),
           1'($urandom), cr, cb, $urandom,
           ($urandom_range(0, 19) == 0),
           5'($urandom_range(0, 9)), ($urandom_range(0, 1) == 1) ? cr : 5'($urandom_range(0, 9)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
